// File: rtl/operand_load_sequencer_pkg.sv
// Shared definitions for the operand load sequencer and its datapath.
// The slot constants fix the op mapping that both sides must agree on.
package operand_load_sequencer_pkg;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2,
        StFlush = 2'd3
    } seq_state_e;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    // Slot fill order A -> B -> C -> D, wrapping back to A.
    function automatic logic [1:0] next_slot(input logic [1:0] slot);
        logic [1:0] nxt;
        case (slot)
            SLOT_A:  nxt = SLOT_B;
            SLOT_B:  nxt = SLOT_C;
            SLOT_C:  nxt = SLOT_D;
            default: nxt = SLOT_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/op_timeout_timer.sv
// Loadable up-counter with clear and enable, flagging terminal count at TIMEOUT-1.
// Priority: clear, then load, then enable.
module op_timeout_timer #(
    parameter int unsigned TO_W    = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            load,
    input  logic [TO_W-1:0] load_value,
    input  logic            enable,
    output logic            tc
);

    localparam logic [TO_W-1:0] TcValue = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q, count_d;

    // Next count selection.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TcValue);

endmodule

// File: rtl/operand_load_sequencer.sv
// Sequencer that streams four operands into the datapath slots, waits for the
// datapath result, and hands it off on a valid/ready port. Owns datapath clear.
module operand_load_sequencer
    import operand_load_sequencer_pkg::*;
#(
    parameter int unsigned W_IN    = 4,
    parameter int unsigned W_RES   = 5,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned TO_W    = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W_IN-1:0]  in_data,
    output logic             in_ready,
    output logic             res_valid,
    output logic [W_RES-1:0] res_data,
    input  logic             res_ready,
    input  logic             flush,
    output logic [1:0]       dp_op,
    output logic             dp_capture,
    output logic [W_IN-1:0]  dp_data,
    output logic             dp_rst_n,
    input  logic [W_RES-1:0] dp_result,
    input  logic             dp_valid,
    output logic             busy,
    output logic             err
);

    seq_state_e       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic             res_valid_q, res_valid_d;
    logic [W_RES-1:0] res_data_q, res_data_d;
    logic             err_q, err_d;
    logic             dp_rst_n_q;
    logic             timer_clear;
    logic             timer_tc;

    // Timer runs only while the FSM stays in WAIT; any other cycle resets it.
    assign timer_clear = (state_q != StWait) || (state_d != StWait);

    op_timeout_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock      (clock),
        .rst_n      (rst_n),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ('0),
        .enable     (1'b1),
        .tc         (timer_tc)
    );

    // Handshake outputs and next-state logic; flush overrides every state.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = 1'b0;
        in_ready    = (state_q == StLoad) && !flush;
        dp_capture  = in_valid && in_ready;

        if (flush) begin
            state_d     = StFlush;
            slot_d      = SLOT_A;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (dp_valid) begin
                        // Datapath cannot be complete before slot D is written.
                        err_d       = 1'b1;
                        state_d     = StFlush;
                        slot_d      = SLOT_A;
                        res_valid_d = 1'b0;
                    end else if (dp_capture) begin
                        slot_d = next_slot(slot_q);
                        if (slot_q == SLOT_D) begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    if (dp_valid) begin
                        res_data_d  = dp_result;
                        res_valid_d = 1'b1;
                        state_d     = StHold;
                    end else if (timer_tc) begin
                        err_d       = 1'b1;
                        state_d     = StFlush;
                        slot_d      = SLOT_A;
                        res_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = StLoad;
                    end
                end
                default: begin
                    state_d = StLoad;
                end
            endcase
        end
    end

    // State and output registers; datapath clear is low throughout FLUSH.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            slot_q      <= SLOT_A;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            dp_rst_n_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            dp_rst_n_q  <= (state_d != StFlush);
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;
    assign dp_rst_n  = dp_rst_n_q;
    assign dp_op     = slot_q;
    assign dp_data   = in_data;
    assign busy      = (state_q != StLoad) || (slot_q != SLOT_A);

endmodule

// File: tb/tb_operand_load_sequencer.sv
// Directed bench for operand_load_sequencer with a transaction-level model
// (operands loaded, wait cycles, pending result, clear cycle) checked every cycle.
module tb_operand_load_sequencer;

    localparam int TIMEOUT = 8;

    logic       clock;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       res_valid;
    logic [4:0] res_data;
    logic       res_ready;
    logic       flush;
    logic [1:0] dp_op;
    logic       dp_capture;
    logic [3:0] dp_data;
    logic       dp_rst_n;
    logic [4:0] dp_result;
    logic       dp_valid;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    operand_load_sequencer dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .flush      (flush),
        .dp_op      (dp_op),
        .dp_capture (dp_capture),
        .dp_data    (dp_data),
        .dp_rst_n   (dp_rst_n),
        .dp_result  (dp_result),
        .dp_valid   (dp_valid),
        .busy       (busy),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operands loaded in the current set (4 = waiting for datapath),
    // cycles spent waiting, pending result, and one-cycle datapath clear.
    int m_loaded, m_wait, m_res;
    bit m_have_res, m_clr, m_err, m_rstn;

    initial begin
        m_loaded = 0; m_wait = 0; m_res = 0;
        m_have_res = 0; m_clr = 0; m_err = 0; m_rstn = 0;
        forever begin
            @(posedge clock or negedge rst_n);
            if (!rst_n) begin
                m_loaded = 0; m_wait = 0; m_res = 0;
                m_have_res = 0; m_clr = 0; m_err = 0; m_rstn = 0;
            end else begin
                m_err = 0;
                if (flush) begin
                    m_loaded = 0; m_wait = 0; m_have_res = 0; m_clr = 1;
                end else if (m_clr) begin
                    m_clr = 0;
                end else if (m_have_res) begin
                    if (res_ready) m_have_res = 0;
                end else if (m_loaded == 4) begin
                    if (dp_valid) begin
                        m_have_res = 1; m_res = int'(dp_result); m_loaded = 0;
                    end else if (m_wait == TIMEOUT - 1) begin
                        m_err = 1; m_loaded = 0; m_wait = 0; m_clr = 1;
                    end else begin
                        m_wait++;
                    end
                end else if (dp_valid) begin
                    m_err = 1; m_loaded = 0; m_clr = 1;
                end else if (in_valid) begin
                    m_loaded++;
                    m_wait = 0;
                end
                m_rstn = !m_clr;
            end
        end
    end

    // Per-cycle compare, mid-cycle when inputs and outputs are settled.
    int cap_ops[$];
    initial begin
        forever begin
            bit exp_ready;
            @(negedge clock);
            exp_ready = !m_have_res && (m_loaded < 4) && !m_clr && !flush;
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("dp_capture", int'(dp_capture), int'(exp_ready && in_valid));
            chk("dp_op", int'(dp_op), m_loaded % 4);
            chk("dp_data", int'(dp_data), int'(in_data));
            chk("busy", int'(busy), int'((m_loaded != 0) || m_have_res || m_clr));
            chk("res_valid", int'(res_valid), int'(m_have_res));
            chk("res_data", int'(res_data), m_res);
            chk("err", int'(err), int'(m_err));
            chk("dp_rst_n", int'(dp_rst_n), int'(m_rstn));
            if (dp_capture) cap_ops.push_back(int'(dp_op));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic put(input logic [3:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int err_cnt, rst_low, err_at;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        flush = 1'b0; dp_result = '0; dp_valid = 1'b0;
        step();
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_dp_rst_n", int'(dp_rst_n), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_dp_rst_n", int'(dp_rst_n), 1);

        // Reset mid-load after two operands.
        put(4'd2); put(4'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_dp_rst_n", int'(dp_rst_n), 0);
        chk("midrst_busy", int'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_in_ready", int'(in_ready), 1);

        // Nominal: 3,5,9,1; dp_valid in the second WAIT cycle.
        cap_ops.delete();
        put(4'd3); put(4'd5); put(4'd9); put(4'd1);
        chk("nom_ops_n", cap_ops.size(), 4);
        for (int i = 0; i < 4 && i < cap_ops.size(); i++) chk("nom_op_seq", cap_ops[i], i);
        step();
        dp_valid = 1'b1; dp_result = 5'h12; res_ready = 1'b1;
        step();
        dp_valid = 1'b0;
        #1;
        chk("nom_res_valid", int'(res_valid), 1);
        chk("nom_res_data", int'(res_data), 'h12);
        step();
        res_ready = 1'b0;
        #1;
        chk("nom_in_ready", int'(in_ready), 1);
        chk("nom_res_dropped", int'(res_valid), 0);

        // Backpressure with an operand offered during HOLD.
        put(4'd1); put(4'd2); put(4'd3); put(4'd4);
        dp_valid = 1'b1; dp_result = 5'h0b;
        step();
        dp_valid = 1'b0; in_valid = 1'b1; in_data = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_data", int'(res_data), 'h0b);
            chk("bp_no_capture", int'(dp_capture), 0);
            step();
        end
        in_valid = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Timeout: datapath never completes.
        put(4'd6); put(4'd6); put(4'd6); put(4'd6);
        err_cnt = 0; rst_low = 0; err_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            #1;
            if (err) begin
                err_cnt++;
                if (err_at < 0) err_at = k;
            end
            if (!dp_rst_n) rst_low++;
        end
        chk("to_err_count", err_cnt, 1);
        chk("to_err_cycle", err_at, TIMEOUT);
        chk("to_rst_low", rst_low, 1);
        chk("to_in_ready", int'(in_ready), 1);

        // Flush mid-load with an operand offered in the same cycle.
        put(4'd8); put(4'd9);
        flush = 1'b1; in_valid = 1'b1; in_data = 4'd6;
        #1;
        chk("fl_no_capture", int'(dp_capture), 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_dp_rst_n", int'(dp_rst_n), 0);
        chk("fl_no_err", int'(err), 0);
        step();
        in_valid = 1'b1; in_data = 4'd5;
        #1;
        chk("fl_next_op", int'(dp_op), 0);
        chk("fl_next_cap", int'(dp_capture), 1);
        step();
        in_valid = 1'b0;

        // Violation: dp_valid while loading at slot 1.
        dp_valid = 1'b1;
        step();
        dp_valid = 1'b0;
        #1;
        chk("vio_err", int'(err), 1);
        chk("vio_dp_rst_n", int'(dp_rst_n), 0);
        step();
        chk("vio_err_gone", int'(err), 0);
        chk("vio_in_ready", int'(in_ready), 1);

        // Flush together with res_ready in HOLD drops the result.
        put(4'd1); put(4'd1); put(4'd1); put(4'd1);
        dp_valid = 1'b1; dp_result = 5'h04;
        step();
        dp_valid = 1'b0; flush = 1'b1; res_ready = 1'b1;
        step();
        flush = 1'b0; res_ready = 1'b0;
        #1;
        chk("hf_res_valid", int'(res_valid), 0);
        chk("hf_dp_rst_n", int'(dp_rst_n), 0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_load_sequencer.md
Name: operand_load_sequencer

Overview:
- Controller in front of the four-slot operand-capture/calculate datapath (slots A,B,C,D selected by op, written on capture, combinational 5-bit result, valid once all four slots are loaded).
- Accepts a stream of 4-bit operands over a valid/ready handshake and steers each one into slot order A→B→C→D.
- Waits for the datapath's valid, latches the result, and presents it on a valid/ready output port.
- Owns datapath clearing on flush or timeout.

Parameters:
- W_IN, 4, operand width.
- W_RES, 5, result width.
- TIMEOUT, 8, cycles allowed in WAIT for dp_valid before an error; must be ≥2.
- TO_W, 4, timer width; must satisfy 2**TO_W ≥ TIMEOUT.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand offered.
- in_data  in  W_IN  operand value.
- in_ready  out  1  sequencer can accept an operand this cycle.
- res_valid  out  1  res_data holds a completed result.
- res_data  out  W_RES  latched datapath result.
- res_ready  in  1  consumer takes the result.
- flush  in  1  synchronous abort of the current operand set.
- dp_op  out  2  datapath slot select: 0=A, 1=B, 2=C, 3=D.
- dp_capture  out  1  datapath write strobe.
- dp_data  out  W_IN  operand to datapath.
- dp_rst_n  out  1  registered active-low clear to the datapath.
- dp_result  in  W_RES  datapath result.
- dp_valid  in  1  datapath reports all slots loaded.
- busy  out  1  operand set in progress or result pending.
- err  out  1  one-cycle pulse on timeout or protocol violation.

Behaviour:
States: LOAD, WAIT, HOLD, FLUSH. Internal 2-bit slot counter and TO_W-bit timer.

Reset (asynchronous, rst_n=0):
- state=LOAD, slot=0, timer=0.
- res_valid=0, res_data=0, err=0, dp_rst_n=0.
- dp_rst_n goes to 1 on the first clock edge after reset releases.

Combinational outputs:
- in_ready = (state==LOAD) & ~flush.
- dp_op = slot.
- dp_data = in_data.
- dp_capture = in_valid & in_ready.
- busy = (state!=LOAD) | (slot!=0).

LOAD:
- On in_valid & in_ready: the operand is written to slot `slot` at this edge, and slot increments.
- An accept at slot 3 sets slot to 0, sets timer to 0, and moves to WAIT.
- dp_valid high while in LOAD is a protocol violation: err pulses and the state moves to FLUSH.

WAIT:
- in_ready=0 and dp_capture=0.
- If dp_valid is sampled high: res_data <= dp_result, res_valid <= 1, move to HOLD.
- Otherwise the timer increments.
- When timer==TIMEOUT-1 with no dp_valid: err pulses and the state moves to FLUSH.
- Minimum latency is 1 cycle from the slot-3 accept edge to res_valid.

HOLD:
- res_valid and res_data stay stable until res_ready.
- On res_valid & res_ready: res_valid <= 0 and the state moves to LOAD.
- No operands are accepted during HOLD (no overlap).
- Back-to-back throughput: 4 load cycles + ≥1 wait cycle + ≥1 hold cycle per result.

FLUSH:
- dp_rst_n=0 for exactly one cycle; slot=0, timer=0, res_valid=0.
- Then moves to LOAD.

flush input:
- Highest priority from any state: the next state is FLUSH.
- An operand offered in the same cycle is not accepted, because in_ready is forced to 0.
- A pending result in HOLD is discarded.

Other rules:
- err is a registered pulse lasting exactly one cycle per event; it does not pulse for a user flush.
- Simultaneous res_ready and flush in HOLD: flush wins and the result is dropped, not handed off.
- dp_rst_n is registered and glitch-free; it is also low during rst_n.

Decomposition:
- Shared package: state encoding (LOAD=2'd0, WAIT=2'd1, HOLD=2'd2, FLUSH=2'd3) and the slot constants SLOT_A..SLOT_D=0..3, so the datapath and this controller share the op mapping.
- Natural sub-module: op_timeout_timer, a loadable counter with clear, enable and a terminal-count flag at TIMEOUT-1. It is reusable for other datapath controllers.
- The FSM and handshake stay in the top level.

Test Plan:
- Reset check: rst_n low mid-LOAD after 2 operands → res_valid=0, err=0, dp_rst_n=0, in_ready=1 after release, slot=0 (next capture has dp_op=0).
- Nominal load: operands 3,5,9,1 offered back-to-back, bench datapath model asserts dp_valid with dp_result=5'h12 one cycle later → dp_op sequence 0,1,2,3 with dp_capture on each; res_valid=1 and res_data=5'h12 two cycles after the first WAIT cycle is entered. With res_ready held high, state returns to LOAD and in_ready=1 next cycle.
- Backpressure: res_ready low for 5 cycles → res_valid and res_data stable throughout; in_valid=1 with in_data=7 during HOLD produces no dp_capture.
- Timeout: model never raises dp_valid after 4 operands → err pulses exactly once, TIMEOUT cycles after entering WAIT; dp_rst_n low for exactly one cycle; then in_ready=1.
- Flush mid-load: flush after 2 operands, with in_valid=1 in the same cycle → no capture that cycle, dp_rst_n low one cycle, no err; the next operand goes to dp_op=0.
- Violation and HOLD flush: dp_valid forced high while in LOAD with slot=1 → err pulse and FLUSH. Separately, flush together with res_ready in HOLD → no handshake completes and res_valid=0 next cycle.
